// File: rtl/lsr_tx_ctrl.sv
// lsr_tx_ctrl: parallel-in, serial-out (MSB first) word sequencer.
// Accepts a word via valid/ready. Each bit advances on a qualified step.
// After every word it inserts a fixed inter-word gap.
// Optional feature: define LSR_PARITY_EN to append an even-parity bit after the data bits.
//
// state  | meaning
// IDLE   | ready for a new word (in_ready=1)
// SHIFT  | data bit shreg[WIDTH-1] on sout, advances on step
// PARITY | parity bit on sout, waits for one step (LSR_PARITY_EN only)
// GAP    | inter-word idle, counts GAP_CYCLES clocks
module lsr_tx_ctrl #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     step,
  input  logic                     abort,
  output logic                     sout,
  output logic                     sout_valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
`ifdef LSR_PARITY_EN
    , PARITY = 2'd3
`endif
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [GW-1:0]    gap_cnt;
  logic             word_end;
`ifdef LSR_PARITY_EN
  logic             parity;
`endif

  // Final qualified step of a word; abort is checked ahead of this in the FSM.
`ifdef LSR_PARITY_EN
  assign word_end = (state == PARITY) && step;
`else
  assign word_end = (state == SHIFT) && step && (bit_cnt == LAST_BIT);
`endif

  // Main sequencer: state, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_ready   <= 1'b0;
`ifdef LSR_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        state      <= IDLE;
        shreg      <= '0;
        bit_cnt    <= '0;
        gap_cnt    <= '0;
        sout       <= 1'b0;
        sout_valid <= 1'b0;
        busy       <= 1'b0;
        in_ready   <= 1'b1;
      end else if (word_end) begin
        done       <= 1'b1;
        shreg      <= '0;
        bit_cnt    <= '0;
        sout       <= 1'b0;
        sout_valid <= 1'b0;
        if (GAP_CYCLES == 0) begin
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end else begin
          state    <= GAP;
          gap_cnt  <= GAP_LOAD;
        end
      end else begin
        case (state)
          IDLE: begin
            // in_ready is low on the first edge after reset, so nothing is taken there.
            if (in_valid && in_ready) begin
              state      <= SHIFT;
              shreg      <= in_data;
              bit_cnt    <= '0;
              sout       <= in_data[WIDTH-1];
              sout_valid <= 1'b1;
              busy       <= 1'b1;
              in_ready   <= 1'b0;
`ifdef LSR_PARITY_EN
              parity     <= ^in_data;
`endif
            end else begin
              in_ready <= 1'b1;
            end
          end
          SHIFT: begin
            if (step) begin
`ifdef LSR_PARITY_EN
              if (bit_cnt == LAST_BIT) begin
                state <= PARITY;
                sout  <= parity;
              end else
`endif
              begin
                shreg   <= {shreg[WIDTH-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
                sout    <= shreg[WIDTH-2];
              end
            end
          end
`ifdef LSR_PARITY_EN
          PARITY: begin
            sout <= parity;
          end
`endif
          GAP: begin
            if (gap_cnt == '0) begin
              state    <= IDLE;
              busy     <= 1'b0;
              in_ready <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
          default: begin
            state      <= IDLE;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsr_tx_ctrl.sv
// Directed bench for lsr_tx_ctrl (WIDTH=4, GAP_CYCLES=1).
// Build with LSR_PARITY_EN defined to also cover the parity bit.
module tb_lsr_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       step;
  logic       abort;
  logic       sout;
  logic       sout_valid;
  logic       busy;
  logic       done;
  logic [1:0] bit_cnt;

  int total = 0;
  int bad   = 0;

  lsr_tx_ctrl #(.WIDTH(4), .GAP_CYCLES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .step       (step),
    .abort      (abort),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done),
    .bit_cnt    (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic e_sout, input logic e_sv,
                         input logic e_busy, input logic e_rdy, input logic e_done,
                         input logic [1:0] e_bc);
    total += 6;
    if (sout !== e_sout) begin
      bad++;
      $error("FAIL %s.sout observed=%0h expected=%0h", tag, sout, e_sout);
    end
    if (sout_valid !== e_sv) begin
      bad++;
      $error("FAIL %s.sout_valid observed=%0h expected=%0h", tag, sout_valid, e_sv);
    end
    if (busy !== e_busy) begin
      bad++;
      $error("FAIL %s.busy observed=%0h expected=%0h", tag, busy, e_busy);
    end
    if (in_ready !== e_rdy) begin
      bad++;
      $error("FAIL %s.in_ready observed=%0h expected=%0h", tag, in_ready, e_rdy);
    end
    if (done !== e_done) begin
      bad++;
      $error("FAIL %s.done observed=%0h expected=%0h", tag, done, e_done);
    end
    if (bit_cnt !== e_bc) begin
      bad++;
      $error("FAIL %s.bit_cnt observed=%0h expected=%0h", tag, bit_cnt, e_bc);
    end
  endtask

  // Full word with step held high: bits, optional parity, done, gap, idle.
  task automatic send_word(input string tag, input logic [3:0] d);
    step     = 1'b1;
    in_data  = d;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_out(tag, d[3-i], 1'b1, 1'b1, 1'b0, 1'b0, 2'(i));
      tick;
    end
`ifdef LSR_PARITY_EN
    chk_out({tag, "_par"}, ^d, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
    tick;
`endif
    chk_out({tag, "_done"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    tick;
    chk_out({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
  endtask

  initial begin
    logic [3:0] d;

    // reset held with traffic on the inputs
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'b1010;
    step     = 1'b1;
    abort    = 1'b0;
    repeat (2) tick;
    chk_out("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    rst = 1'b1;
    tick;
    chk_out("rst_rel", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    in_valid = 1'b0;
    tick;
    chk_out("rst_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);

    // basic word, step always high
    send_word("w1001", 4'b1001);

    // step toggling: each bit held two cycles
    d        = 4'b1100;
    in_data  = d;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step = i[0];
      chk_out("toggle", d[3-i/2], 1'b1, 1'b1, 1'b0, 1'b0, 2'(i/2));
      tick;
    end
`ifdef LSR_PARITY_EN
    step = 1'b0;
    chk_out("toggle_par0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
    tick;
    step = 1'b1;
    chk_out("toggle_par1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
    tick;
`endif
    step = 1'b1;
    chk_out("toggle_done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    tick;
    chk_out("toggle_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);

    // in_valid held while busy must not disturb the word in flight
    d        = 4'b1010;
    in_data  = d;
    in_valid = 1'b1;
    tick;
    in_data  = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      chk_out("busy_in", d[3-i], 1'b1, 1'b1, 1'b0, 1'b0, 2'(i));
      tick;
    end
`ifdef LSR_PARITY_EN
    chk_out("busy_in_par", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
    tick;
`endif
    chk_out("busy_in_done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    tick;
    chk_out("busy_in_rdy", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    tick;
    in_valid = 1'b0;
    d        = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      chk_out("second", d[3-i], 1'b1, 1'b1, 1'b0, 1'b0, 2'(i));
      tick;
    end
`ifdef LSR_PARITY_EN
    chk_out("second_par", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
    tick;
`endif
    chk_out("second_done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    tick;
    chk_out("second_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);

    // abort after two bits; abort outranks step
    in_data  = 4'b1111;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk_out("abort_b0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    tick;
    chk_out("abort_b1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    tick;
    chk_out("abort_b2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk_out("abort_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    tick;
    chk_out("abort_nodone", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);

    // abort in IDLE must not block acceptance
    abort    = 1'b1;
    in_valid = 1'b1;
    tick;
    abort    = 1'b0;
    in_valid = 1'b0;
    chk_out("abort_idle_acc", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    tick;
    chk_out("mid_b1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);

    // asynchronous reset mid-word clears at once
    #1 rst = 1'b0;
    #1 chk_out("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    rst = 1'b1;
    tick;
    chk_out("rst_mid_rel", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);

    // parity vectors (odd and even word weight)
    send_word("w1011", 4'b1011);
    send_word("w1001b", 4'b1001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
